// File: rtl/sec32_encoder.sv
// sec32_encoder -- two-stage valid/ready pipeline that appends 8 SEC check
// bits to each 32-bit data word, bit-compatible with the companion 32-bit
// SEC corrector.
//
// Optional feature: define SEC32_ENC_ERRINJ_EN to compile single-bit error
// injection (err_inj/err_pos). Without it those inputs are accepted but
// ignored and every codeword is clean.
//
// Ports
//   clk        : clock, all state on its rising edge
//   rst        : asynchronous active-high reset
//   flush      : synchronous clear of both stage valids
//   in_valid   : in_data valid
//   in_ready   : block accepts in_data this cycle
//   in_data    : data word d[31:0]
//   out_valid  : codeword valid
//   out_ready  : sink accepts codeword
//   out_data   : data bits of the codeword
//   out_chk    : check bits c[7:0] of the codeword
//   err_inj    : corrupt the word accepted this cycle (feature build only)
//   err_pos    : codeword bit to flip, 0-31 data, 32-39 check, 40-63 none
//   word_cnt   : saturating count of delivered codewords
module sec32_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [7:0]       out_chk,
  input  logic             err_inj,
  input  logic [5:0]       err_pos,
  output logic [CNT_W-1:0] word_cnt
);

  // Codeword as carried by the output stage: {check, data}.
  typedef struct packed {
    logic [7:0]  chk;
    logic [31:0] data;
  } cw_t;

  // Each check bit is the XOR of 12 data bits; the pattern must match the
  // corrector's syndrome decode exactly, so it is spelled out bit by bit.
  function automatic logic [7:0] calc_chk(input logic [31:0] d);
    logic [7:0] c;
    c[0] = d[0]  ^ d[4]  ^ d[8]  ^ d[12] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    c[1] = d[1]  ^ d[5]  ^ d[9]  ^ d[13] ^ d[24] ^ d[25] ^ d[26] ^ d[27]
         ^ d[28] ^ d[29] ^ d[30] ^ d[31];
    c[2] = d[2]  ^ d[6]  ^ d[10] ^ d[14] ^ d[16] ^ d[17] ^ d[18] ^ d[19]
         ^ d[24] ^ d[25] ^ d[26] ^ d[27];
    c[3] = d[3]  ^ d[7]  ^ d[11] ^ d[15] ^ d[20] ^ d[21] ^ d[22] ^ d[23]
         ^ d[28] ^ d[29] ^ d[30] ^ d[31];
    c[4] = d[16] ^ d[20] ^ d[24] ^ d[28] ^ d[0]  ^ d[1]  ^ d[2]  ^ d[3]
         ^ d[4]  ^ d[5]  ^ d[6]  ^ d[7];
    c[5] = d[17] ^ d[21] ^ d[25] ^ d[29] ^ d[8]  ^ d[9]  ^ d[10] ^ d[11]
         ^ d[12] ^ d[13] ^ d[14] ^ d[15];
    c[6] = d[18] ^ d[22] ^ d[26] ^ d[30] ^ d[0]  ^ d[1]  ^ d[2]  ^ d[3]
         ^ d[8]  ^ d[9]  ^ d[10] ^ d[11];
    c[7] = d[19] ^ d[23] ^ d[27] ^ d[31] ^ d[4]  ^ d[5]  ^ d[6]  ^ d[7]
         ^ d[12] ^ d[13] ^ d[14] ^ d[15];
    return c;
  endfunction

  // Stage 1: raw input word
  logic        s1_vld_q,  s1_vld_d;
  logic [31:0] s1_data_q, s1_data_d;
  // Stage 2: finished codeword, drives the outputs directly
  logic        s2_vld_q,  s2_vld_d;
  cw_t         s2_cw_q,   s2_cw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic s2_adv, s1_adv, in_fire, out_fire;
  cw_t  s1_cw;

`ifdef SEC32_ENC_ERRINJ_EN
  // Pending injection travels with the word in S1 and is applied at S2 load.
  logic       s1_inj_q, s1_inj_d;
  logic [5:0] s1_pos_q, s1_pos_d;
`else
  logic unused_errinj;
  assign unused_errinj = ^{err_inj, err_pos};
`endif

  // Handshake control. flush blocks every handshake in its cycle; rst
  // forces in_ready low for as long as it is held.
  always_comb begin
    s2_adv   = !s2_vld_q || out_ready;
    s1_adv   = !s1_vld_q || s2_adv;
    in_ready = !rst && !flush && s1_adv;
    in_fire  = in_valid && in_ready;
    out_fire = s2_vld_q && out_ready && !flush;
  end

  // Codeword built from S1, including the optional single-bit flip.
  always_comb begin
    s1_cw.data = s1_data_q;
    s1_cw.chk  = calc_chk(s1_data_q);
`ifdef SEC32_ENC_ERRINJ_EN
    if (s1_inj_q)
      s1_cw = s1_cw ^ cw_t'(40'd1 << s1_pos_q);
`endif
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s2_vld_d  = s2_vld_q;
    s2_cw_d   = s2_cw_q;
    cnt_d     = cnt_q;
`ifdef SEC32_ENC_ERRINJ_EN
    s1_inj_d  = s1_inj_q;
    s1_pos_d  = s1_pos_q;
`endif
    if (flush) begin
      s1_vld_d = 1'b0;
      s2_vld_d = 1'b0;
`ifdef SEC32_ENC_ERRINJ_EN
      s1_inj_d = 1'b0;
`endif
    end else begin
      if (s2_adv) begin
        s2_vld_d = s1_vld_q;
        // Only load payload when a word is actually moving so the output
        // bus does not toggle on bubbles.
        if (s1_vld_q)
          s2_cw_d = s1_cw;
      end
      if (s1_adv) begin
        s1_vld_d = in_fire;
        if (in_fire)
          s1_data_d = in_data;
`ifdef SEC32_ENC_ERRINJ_EN
        // Positions 40-63 name no codeword bit, so they never arm a flip.
        s1_inj_d = in_fire && err_inj && (err_pos < 6'd40);
        if (in_fire)
          s1_pos_d = err_pos;
`endif
      end
      if (out_fire && (cnt_q != {CNT_W{1'b1}}))
        cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s2_vld_q  <= 1'b0;
      s2_cw_q   <= '0;
      cnt_q     <= '0;
`ifdef SEC32_ENC_ERRINJ_EN
      s1_inj_q  <= 1'b0;
      s1_pos_q  <= '0;
`endif
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s2_vld_q  <= s2_vld_d;
      s2_cw_q   <= s2_cw_d;
      cnt_q     <= cnt_d;
`ifdef SEC32_ENC_ERRINJ_EN
      s1_inj_q  <= s1_inj_d;
      s1_pos_q  <= s1_pos_d;
`endif
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_cw_q.data;
  assign out_chk   = s2_cw_q.chk;
  assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_sec32_encoder.sv
// Bench for sec32_encoder: directed vectors with hand-computed check bytes,
// stall/flush/reset scenarios, and a scoreboarded stream. Inputs change 1ns
// after the rising edge; outputs and handshakes are sampled on the falling
// edge.
module tb_sec32_encoder;
  localparam int CNT_W = 7;   // small counter so saturation is reachable

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_data, out_data;
  logic [7:0]       out_chk;
  logic             err_inj;
  logic [5:0]       err_pos;
  logic [CNT_W-1:0] word_cnt;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [7:0]  chk;
    logic [31:0] data;
  } cw_t;
  cw_t sbq[$];

  // Check-bit masks: c[i] = parity(d & MASK[i]).
  localparam logic [31:0] MASK [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};

  function automatic logic [7:0] model_chk(input logic [31:0] d);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[i] = ^(d & MASK[i]);
    return c;
  endfunction

  sec32_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chk(out_chk),
    .err_inj(err_inj), .err_pos(err_pos), .word_cnt(word_cnt));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard producer: expected codeword recorded at each input handshake.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      cw_t e;
      e.data = in_data;
      e.chk  = model_chk(in_data);
`ifdef SEC32_ENC_ERRINJ_EN
      if (err_inj && err_pos < 6'd40) e = e ^ cw_t'(40'd1 << err_pos);
`endif
      sbq.push_back(e);
    end
  end

  // Scoreboard consumer: compare at each output handshake; flush/reset
  // discard everything in flight.
  always @(negedge clk) begin
    if (rst || flush) sbq.delete();
    else if (out_valid && out_ready) begin
      if (sbq.size() == 0) check("sb_empty", 64'd1, 64'd0);
      else begin
        cw_t e;
        e = sbq.pop_front();
        check("sb_data", 64'(out_data), 64'(e.data));
        check("sb_chk",  64'(out_chk),  64'(e.chk));
      end
    end
  end

  // One word with out_ready high. Presented in cycle k, it sits in S1 during
  // cycle k+1 and is on out_* during cycle k+2.
  task automatic send_one(input logic [31:0] d, input logic [7:0] exp_chk,
                          input logic inj, input logic [5:0] pos);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; out_ready = 1'b1;
    err_inj = inj; err_pos = pos;
    @(negedge clk);
    check("acc_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; err_inj = 1'b0;
    check("lat_s1_only", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("vec_data",  64'(out_data),  64'(d));
    check("vec_chk",   64'(out_chk),   64'(exp_chk));
    @(posedge clk); #1;
  endtask

  // n random words, out_ready toggled randomly, then drain.
  task automatic stream(input int n);
    int i = 0;
    int cyc = 0;
    logic [31:0] cur = $urandom;
    while (i < n && cyc < 4000) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = cur;
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin i++; cur = $urandom; end
      cyc++;
    end
    if (i < n) check("stream_timeout", 64'(i), 64'(n));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    cyc = 0;
    while ((out_valid || sbq.size() != 0) && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("stream_drained", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    int acc;
    logic [31:0] first_w;
    logic [CNT_W-1:0] cnt0;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b0; err_inj = 1'b0; err_pos = '0;
    #2;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_chk",   64'(out_chk),   64'd0);
    check("rst_word_cnt",  64'(word_cnt),  64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors, hand-computed check bytes
    send_one(32'h00000001, 8'h51, 1'b0, 6'd0);
    send_one(32'h00010000, 8'h15, 1'b0, 6'd0);
    send_one(32'h80000000, 8'h8A, 1'b0, 6'd0);
    send_one(32'hFFFFFFFF, 8'h00, 1'b0, 6'd0);
    send_one(32'h0000000F, 8'h0F, 1'b0, 6'd0);
    check("cnt_after_vec", 64'(word_cnt), 64'd5);

    // Stall: out_ready low for 10 cycles with in_valid high
    acc = 0; first_w = '0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hA5A50000 + k;
      @(negedge clk);
      if (in_ready) begin
        if (acc == 0) first_w = in_data;
        acc++;
      end
      if (out_valid) begin
        check("stall_data", 64'(out_data), 64'(first_w));
        check("stall_chk",  64'(out_chk),  64'(model_chk(first_w)));
      end
    end
    check("stall_accepts",  64'(acc),      64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_after_stall", 64'(word_cnt), 64'd7);

    // Flush with both stages full
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1; in_valid = 1'b1; in_data = 32'h12340000 + k;
    end
    @(posedge clk); #1;
    cnt0 = word_cnt;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_word_cnt",  64'(word_cnt),  64'(cnt0));
    send_one(32'h00010000, 8'h15, 1'b0, 6'd0);

    // Error injection: flip bit 35 (chk[3]); following word clean;
    // out-of-range position injects nothing.
`ifdef SEC32_ENC_ERRINJ_EN
    send_one(32'h00000001, 8'h59, 1'b1, 6'd35);
`else
    send_one(32'h00000001, 8'h51, 1'b1, 6'd35);
`endif
    send_one(32'h00000001, 8'h51, 1'b0, 6'd35);
    send_one(32'h80000000, 8'h8A, 1'b1, 6'd45);

    // Reset asserted mid-stream
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hCAFE0000 + k;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'd0);
    check("mrst_out_data",  64'(out_data),  64'd0);
    check("mrst_out_chk",   64'(out_chk),   64'd0);
    check("mrst_word_cnt",  64'(word_cnt),  64'd0);
    check("mrst_in_ready",  64'(in_ready),  64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("mrst_rel_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst_no_stale", 64'(out_valid), 64'd0);
    end

    // 100-word random stream from a freshly reset counter, then saturation
    stream(100);
    check("stream_cnt", 64'(word_cnt), 64'd100);
    stream(30);
    check("sat_cnt", 64'(word_cnt), 64'd127);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end
endmodule
